// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding and memory-wait controller for the 5-stage pipeline.
// Optional perf counters: define HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int          MEM_TIMEOUT = 16,
  parameter logic [3:0]  REG_PC      = 4'd15
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       PCSrcD,
  input  logic       PCSrcE,
  input  logic       PCSrcM,
  input  logic       PCSrcW,
  input  logic       BranchTakenE,
  input  logic       MemReqM,
  input  logic       MemReadyM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
`ifdef HAZARD_PERF_CNT_EN
  output logic       MemErr,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
`else
  output logic       MemErr
`endif
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    M_IDLE,
    M_WAIT,
    M_ERR
  } mstate_e;

  mstate_e       state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          mem_stall;
  logic          ld_stall;
  logic          pc_wr_pend;

  function automatic logic [1:0] fwd_sel(input logic [3:0] ra);
    logic [1:0] sel;
    sel = 2'b00;
    if (ra != REG_PC) begin
      if (RegWriteM && ra == WA3M)      sel = 2'b10;
      else if (RegWriteW && ra == WA3W) sel = 2'b01;
    end
    return sel;
  endfunction

  // Load-use and in-flight PC-write hazard detection
  always_comb begin
    ld_stall   = MemtoRegE & RegWriteE &
                 (((RA1D == WA3E) & (RA1D != REG_PC)) |
                  ((RA2D == WA3E) & (RA2D != REG_PC)));
    pc_wr_pend = PCSrcD | PCSrcE | PCSrcM;
  end

  // Memory handshake FSM: next state, wait counter and freeze request
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_stall  = 1'b0;
    case (state_q)
      M_IDLE: begin
        mem_stall = MemReqM & ~MemReadyM;
        if (mem_stall) begin
          state_d    = M_WAIT;
          wait_cnt_d = CW'(1);
        end
      end
      M_WAIT: begin
        mem_stall = ~MemReadyM;
        if (MemReadyM) begin
          state_d    = M_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CW'(MEM_TIMEOUT - 1)) begin
          state_d = M_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      M_ERR: begin
        mem_stall = 1'b0;
      end
      default: begin
        state_d    = M_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // FSM state and wait counter registers, synchronous reset
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= M_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Pipeline control outputs; memory freeze overrides, reset forces bubbles
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    FlushW    = 1'b1;
    if (RESET) begin
      ForwardAE = fwd_sel(RA1E);
      ForwardBE = fwd_sel(RA2E);
      if (mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b1;
      end else begin
        StallF = ld_stall | pc_wr_pend;
        StallD = ld_stall;
        FlushD = pc_wr_pend | PCSrcW | BranchTakenE;
        FlushE = ld_stall | BranchTakenE;
        FlushW = 1'b0;
      end
    end
  end

  assign MemErr = (state_q == M_ERR);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Saturating counters of fetch-stall cycles and branch-induced E flushes
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (StallF && stall_cycles_q != 32'hFFFF_FFFF)
      stall_cycles_d = stall_cycles_q + 32'd1;
    if (RESET && !mem_stall && BranchTakenE &&
        flush_count_q != 32'hFFFF_FFFF)
      flush_count_d = flush_count_q + 32'd1;
  end

  // Perf counter registers
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign StallCycles = stall_cycles_q;
  assign FlushCount  = flush_count_q;
`endif

endmodule
